// File: rtl/npu_mat_pkg.sv
// Shared types for the NPU 4x4 elementwise matrix path (loader and compute stages).
package npu_mat_pkg;
    localparam int DIM = 4;
    localparam int DW  = 8;

    typedef logic [DW-1:0] elem_t;
    typedef elem_t [DIM-1:0][DIM-1:0] mat_t;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, FIRE, WAIT} ld_state_t;
endpackage

// File: rtl/mat_operand_loader_if.sv
// Stream-in and compute-side signals of the operand loader.
interface mat_operand_loader_if #(parameter int CNTW = 16);
    import npu_mat_pkg::*;

    logic            flush;
    logic            in_valid;
    elem_t           in_data;
    logic            in_ready;
    mat_t            a_out;
    mat_t            b_out;
    logic            start;
    logic            done_in;
    logic            busy;
    logic [CNTW-1:0] op_count;

    modport slave (
        input  flush, in_valid, in_data, done_in,
        output in_ready, a_out, b_out, start, busy, op_count
    );
    modport master (
        output flush, in_valid, in_data, done_in,
        input  in_ready, a_out, b_out, start, busy, op_count
    );
endinterface

// File: rtl/mat_operand_loader.sv
// Fills operand A then B from a byte stream, pulses start, holds operands until
// the compute stage signals done. DIM/DW come from npu_mat_pkg.
module mat_operand_loader
    import npu_mat_pkg::*;
#(
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mat_operand_loader_if.slave  bus
);
    localparam int NEL = DIM * DIM;
    localparam int IW  = $clog2(NEL);
    localparam int RW  = $clog2(DIM);

    ld_state_t       state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    mat_t            a_q, b_q;
    logic            start_q, busy_q, done_prev_q;
    logic [CNTW-1:0] cnt_q;

    logic            loading, rdy, accept, last, done_evt, cnt_inc;
    logic [RW-1:0]   row, col;

    assign loading  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign rdy      = loading && !bus.flush;
    assign accept   = bus.in_valid && rdy;
    assign last     = (idx_q == IW'(NEL - 1));
    assign done_evt = bus.done_in && !done_prev_q;
    assign row      = RW'(idx_q / IW'(DIM));
    assign col      = RW'(idx_q % IW'(DIM));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_inc = 1'b0;
        if (bus.flush) begin
            state_d = LOAD_A;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                LOAD_A, LOAD_B: begin
                    if (accept) begin
                        if (last) begin
                            idx_d   = '0;
                            state_d = (state_q == LOAD_A) ? LOAD_B : FIRE;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                FIRE: state_d = WAIT;
                WAIT: begin
                    if (done_evt) begin
                        cnt_inc = 1'b1;
                        state_d = LOAD_A;
                        idx_d   = '0;
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    // done_prev tracks done_in in every state so a sticky done cannot re-fire later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_prev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            start_q     <= (state_d == FIRE);
            busy_q      <= (state_d == FIRE) || (state_d == WAIT);
            done_prev_q <= bus.done_in;
            if (cnt_inc)
                cnt_q <= cnt_q + CNTW'(1);
            if (accept && state_q == LOAD_A)
                a_q[row][col] <= bus.in_data;
            if (accept && state_q == LOAD_B)
                b_q[row][col] <= bus.in_data;
        end
    end

    // A flush landing on the FIRE cycle must kill the pulse already registered.
    assign bus.start    = start_q && !bus.flush;
    assign bus.in_ready = rdy;
    assign bus.busy     = busy_q;
    assign bus.op_count = cnt_q;
    assign bus.a_out    = a_q;
    assign bus.b_out    = b_q;
endmodule
